// File: rtl/audio_pkg.sv
// Shared audio-path constants and types for the I2S transmitter.
//   I2S_SLOT_BITS / I2S_FRAME_BITS : standard I2S framing (two 32-bit slots)
//   DEFAULT_SCLK_DIV               : mclk cycles per bit clock at 12.288/3.072 MHz
//   stereo_frame_t                 : one stereo sample pair, sized for the widest sample
//   tx_state_t                     : transmitter sequencing state
package audio_pkg;

   localparam int I2S_SLOT_BITS    = 32;
   localparam int I2S_FRAME_BITS   = 64;
   localparam int DEFAULT_SCLK_DIV = 4;
   localparam int MAX_DATA_WIDTH   = 24;

   typedef struct packed {
      logic [MAX_DATA_WIDTH-1:0] left;
      logic [MAX_DATA_WIDTH-1:0] right;
   } stereo_frame_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_RUN  = 1'b1
   } tx_state_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Valid/ready stereo sample source bus feeding the I2S transmitter.
//   s_valid : source offers a stereo frame
//   s_ready : sink can take the frame this cycle
//   s_left  : left sample, two's complement
//   s_right : right sample, two's complement
interface audio_i2s_tx_if #(
   parameter int DATA_WIDTH = 16
) ();

   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_left;
   logic [DATA_WIDTH-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for stereo sample frames, show-ahead read port.
//   clk, reset   : clock, synchronous active-high reset (flushes contents)
//   push_i       : write request, ignored while full
//   push_data_i  : frame to write
//   pop_i        : read request, ignored while empty
//   pop_data_o   : oldest frame (valid while !empty_o)
//   full_o       : DEPTH frames held
//   empty_o      : no frames held
//   level_o      : number of frames held
module audio_sample_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o     = (level_q == LVL_FULL);
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign push_ok    = push_i & ~full_o;
   assign pop_ok     = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; the level counter qualifies every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: buffers frames from a valid/ready source and
// serialises them MSB-first, one bit delay after the word-select edge,
// 32-bit slots, 64 bit clocks per frame, all derived from mclk.
//   mclk        : audio master clock
//   reset       : synchronous active-high reset
//   pll_locked  : transmitter runs only while high
//   src         : stereo frame source (valid/ready, left/right samples)
//   sclk_out    : I2S bit clock
//   lrclk       : word select, 0 = left, 1 = right
//   sdata       : serial data
//   underrun    : one-mclk pulse when a frame start finds the FIFO empty
//   fifo_level  : frames currently buffered
//
// state   | meaning
// TX_IDLE | unlocked or just reset; next locked edge is a frame start
// TX_RUN  | counters free-running, frame start on bit_cnt/div_cnt wrap
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SCLK_DIV   = DEFAULT_SCLK_DIV
) (
   input  logic                            mclk,
   input  logic                            reset,
   input  logic                            pll_locked,
   audio_i2s_tx_if.slave                   src,
   output logic                            sclk_out,
   output logic                            lrclk,
   output logic                            sdata,
   output logic                            underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

   localparam int DIV_W = $clog2(SCLK_DIV);
   localparam int BIT_W = $clog2(I2S_FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV-1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV/2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(I2S_FRAME_BITS-1);
   localparam logic [5:0]       DW6      = 6'(DATA_WIDTH);

   tx_state_t             state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic [DATA_WIDTH-1:0] right_q, right_d;
   logic                  sclk_q, sclk_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  underrun_q, underrun_d;

   logic                    frame_start;
   logic                    fifo_pop, fifo_full, fifo_empty;
   logic [2*DATA_WIDTH-1:0] fifo_rd_data;
   logic [5:0]              slot_pos;
   logic [DATA_WIDTH-1:0]   slot_word;
   logic [DATA_WIDTH-1:0]   slot_shift;

   audio_sample_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (mclk),
      .reset       (reset),
      .push_i      (src.s_valid),
      .push_data_i ({src.s_left, src.s_right}),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_rd_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign src.s_ready = ~fifo_full;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      left_d      = left_q;
      right_d     = right_q;
      frame_start = 1'b0;
      fifo_pop    = 1'b0;
      sclk_d      = 1'b0;
      lrclk_d     = 1'b0;
      sdata_d     = 1'b0;
      underrun_d  = 1'b0;
      slot_pos    = '0;
      slot_word   = '0;
      slot_shift  = '0;

      if (!pll_locked) begin
         state_d = TX_IDLE;
         div_d   = '0;
         bit_d   = '0;
         left_d  = '0;
         right_d = '0;
      end else begin
         if (state_q == TX_IDLE) begin
            // First locked edge enters 0/0 and counts as a frame start.
            state_d     = TX_RUN;
            div_d       = '0;
            bit_d       = '0;
            frame_start = 1'b1;
         end else if (div_q == DIV_LAST) begin
            div_d       = '0;
            bit_d       = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
            frame_start = (bit_q == BIT_LAST);
         end else begin
            div_d = div_q + 1'b1;
         end

         if (frame_start) begin
            fifo_pop   = ~fifo_empty;
            underrun_d = fifo_empty;
            if (fifo_empty) begin
               left_d  = '0;
               right_d = '0;
            end else begin
               {left_d, right_d} = fifo_rd_data;
            end
         end

         // Outputs follow the counter values being entered so they line up
         // with div_cnt; data only moves when div_d returns to 0.
         sclk_d    = (div_d >= DIV_HALF);
         lrclk_d   = bit_d[5];
         slot_pos  = {1'b0, bit_d[4:0]};
         slot_word = bit_d[5] ? right_d : left_d;
         if ((slot_pos != 6'd0) && (slot_pos <= DW6)) begin
            slot_shift = slot_word >> (DW6 - slot_pos);
            sdata_d    = slot_shift[0];
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q    <= TX_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         left_q     <= '0;
         right_q    <= '0;
         sclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         left_q     <= left_d;
         right_q    <= right_d;
         sclk_q     <= sclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
      end
   end

   assign sclk_out = sclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with a frame scoreboard: frames are
// queued when pushed and checked bit by bit when a frame start sends them.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
   import audio_pkg::*;

   localparam int DW = 16;

   logic       mclk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       sclk_out, lrclk, sdata, underrun;
   logic [2:0] fifo_level;
   logic [2:0] lv;
   logic       rd;

   int total = 0;
   int bad   = 0;

   stereo_frame_t sb_q[$];

   audio_i2s_tx_if #(.DATA_WIDTH(DW)) src_if ();

   audio_i2s_tx #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4),
      .SCLK_DIV   (4)
   ) dut (
      .mclk       (mclk),
      .reset      (reset),
      .pll_locked (pll_locked),
      .src        (src_if),
      .sclk_out   (sclk_out),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   always #5 mclk = ~mclk;

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input string what,
                      input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s_%s got=%0h exp=%0h", tag, what, got, exp);
      end
   endtask

   function automatic stereo_frame_t mk(input logic [DW-1:0] l, input logic [DW-1:0] r);
      stereo_frame_t f;
      f = '0;
      f.left[DW-1:0]  = l;
      f.right[DW-1:0] = r;
      return f;
   endfunction

   // Expected sdata per bit slot: bit b of the frame carries sample bit
   // (DW-p), p = b mod 32, for p in 1..DW; everything else is 0.
   function automatic logic [63:0] exp_vec(input stereo_frame_t f);
      logic [63:0]   v;
      logic [DW-1:0] s;
      int            p;
      v = '0;
      for (int b = 0; b < 64; b++) begin
         p = b % 32;
         s = (b < 32) ? f.left[DW-1:0] : f.right[DW-1:0];
         if (p >= 1 && p <= DW) v[b] = s[DW-p];
      end
      return v;
   endfunction

   task automatic outs_zero(input string tag);
      chk(tag, "outs", 64'({sclk_out, lrclk, sdata, underrun}), 64'(0));
   endtask

   task automatic unlock(input string tag);
      pll_locked = 1'b0;
      tick();
      outs_zero(tag);
   endtask

   task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      src_if.s_valid = 1'b1;
      src_if.s_left  = l;
      src_if.s_right = r;
      sb_q.push_back(mk(l, r));
      tick();
      src_if.s_valid = 1'b0;
   endtask

   // Call when the next mclk edge is a frame start. Runs ncyc edges,
   // optionally pushing a frame on edge push_k (0 = the frame-start edge).
   task automatic run_frame(input string tag, input int ncyc, input int push_k,
                            input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                            output logic [2:0] lvl0, output logic rdy0);
      stereo_frame_t f;
      logic          exp_ur;
      logic [63:0]   ev, gv, mask;
      int            e_sclk, e_lr, e_ur, e_sd;
      e_sclk = 0; e_lr = 0; e_ur = 0; e_sd = 0;
      if (sb_q.size() == 0) begin
         f = '0;
         exp_ur = 1'b1;
      end else begin
         f = sb_q.pop_front();
         exp_ur = 1'b0;
      end
      ev = exp_vec(f);
      gv = '0;
      mask = '0;
      lvl0 = '0;
      rdy0 = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (k == push_k) begin
            src_if.s_valid = 1'b1;
            src_if.s_left  = pl;
            src_if.s_right = pr;
            sb_q.push_back(mk(pl, pr));
         end
         tick();
         src_if.s_valid = 1'b0;
         if (k == 0) begin
            lvl0 = fifo_level;
            rdy0 = src_if.s_ready;
         end
         if (sclk_out !== ((k % 4) >= 2)) e_sclk++;
         if (lrclk !== ((k / 4) >= 32)) e_lr++;
         if (underrun !== ((k == 0) && exp_ur)) e_ur++;
         if (k % 4 == 0) begin
            gv[k/4]   = sdata;
            mask[k/4] = 1'b1;
         end else if (sdata !== gv[k/4]) begin
            e_sd++;
         end
      end
      chk(tag, "sdata", gv & mask, ev & mask);
      chk(tag, "sdata_unstable", 64'(e_sd), 64'(0));
      chk(tag, "sclk_err", 64'(e_sclk), 64'(0));
      chk(tag, "lrclk_err", 64'(e_lr), 64'(0));
      chk(tag, "underrun_err", 64'(e_ur), 64'(0));
   endtask

   initial begin
      src_if.s_valid = 1'b0;
      src_if.s_left  = '0;
      src_if.s_right = '0;

      // Reset
      reset = 1'b1;
      tick();
      chk("rst", "ready_during", 64'(src_if.s_ready), 64'(1));
      tick();
      tick();
      outs_zero("rst");
      chk("rst", "level", 64'(fifo_level), 64'(0));
      reset = 1'b0;
      tick();
      outs_zero("unlocked_idle");
      chk("unlocked_idle", "ready", 64'(src_if.s_ready), 64'(1));

      // Lock with nothing queued: zero frames, underrun each frame start
      pll_locked = 1'b1;
      run_frame("idle0", 256, -1, '0, '0, lv, rd);
      run_frame("idle1", 256, -1, '0, '0, lv, rd);

      // One known frame pushed before lock
      unlock("unlk_b");
      push_frame(16'hA5C3, 16'h8001);
      chk("a5c3", "level_pre", 64'(fifo_level), 64'(1));
      pll_locked = 1'b1;
      run_frame("a5c3", 256, -1, '0, '0, lv, rd);
      chk("a5c3", "level_at_start", 64'(lv), 64'(0));

      // Fill the FIFO
      unlock("unlk_c");
      push_frame(16'h1234, 16'hFEDC);
      push_frame(16'h0001, 16'h8000);
      push_frame(16'hFFFF, 16'h5555);
      push_frame(16'hC0DE, 16'h0BAD);
      chk("full", "ready", 64'(src_if.s_ready), 64'(0));
      chk("full", "level", 64'(fifo_level), 64'(4));
      pll_locked = 1'b1;
      run_frame("q0", 256, -1, '0, '0, lv, rd);
      chk("q0", "level_at_start", 64'(lv), 64'(3));
      chk("q0", "ready_at_start", 64'(rd), 64'(1));
      run_frame("q1", 256, -1, '0, '0, lv, rd);
      run_frame("q2", 256, -1, '0, '0, lv, rd);
      run_frame("q3", 256, -1, '0, '0, lv, rd);
      chk("q3", "level_at_start", 64'(lv), 64'(0));

      // Push on the frame-start edge with the FIFO empty
      run_frame("ur_push", 256, 0, 16'h7E81, 16'h0FF0, lv, rd);
      chk("ur_push", "level_at_start", 64'(lv), 64'(1));
      run_frame("pushed", 256, -1, '0, '0, lv, rd);
      chk("pushed", "level_at_start", 64'(lv), 64'(0));

      // Lose lock at bit_cnt 20 with two frames still queued
      unlock("unlk_e");
      push_frame(16'h3C3C, 16'hAAAA);
      push_frame(16'h9669, 16'h0F0F);
      push_frame(16'h4321, 16'h8765);
      pll_locked = 1'b1;
      run_frame("pre_drop", 81, -1, '0, '0, lv, rd);
      chk("pre_drop", "level_at_start", 64'(lv), 64'(2));
      pll_locked = 1'b0;
      tick();
      outs_zero("drop");
      chk("drop", "level", 64'(fifo_level), 64'(2));
      tick();
      chk("drop", "level_hold", 64'(fifo_level), 64'(2));
      pll_locked = 1'b1;
      run_frame("relock", 256, -1, '0, '0, lv, rd);
      chk("relock", "level_at_start", 64'(lv), 64'(1));

      // Reset mid-frame with three frames queued
      unlock("unlk_f");
      push_frame(16'h1111, 16'h2222);
      push_frame(16'h3333, 16'h4444);
      push_frame(16'h5555, 16'h6666);
      chk("pre_rst", "level_pre", 64'(fifo_level), 64'(4));
      pll_locked = 1'b1;
      run_frame("pre_rst", 100, -1, '0, '0, lv, rd);
      chk("pre_rst", "level_at_start", 64'(lv), 64'(3));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_q.delete();
      outs_zero("mid_rst");
      chk("mid_rst", "level", 64'(fifo_level), 64'(0));
      chk("mid_rst", "ready", 64'(src_if.s_ready), 64'(1));
      run_frame("post_rst", 256, -1, '0, '0, lv, rd);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
